// File: rtl/sector_lru_cache_sim_if.sv
// Request/response bus of the set-associative cache model: one address per
// request over valid/ready, one-cycle response strobe with hit/way/evict info.
interface sector_lru_cache_sim_if #(
  parameter int ADDR_W = 31,
  parameter int WAY_W  = 5
);
  logic              req_valid_41;
  logic              req_ready_41;
  logic [ADDR_W-1:0] req_addr_41;
  logic              req_write_41;
  logic              resp_valid_41;
  logic              resp_hit_41;
  logic [WAY_W-1:0]  resp_way_41;
  logic              resp_evict_dirty_41;

  modport master (
    output req_valid_41, req_addr_41, req_write_41,
    input  req_ready_41, resp_valid_41, resp_hit_41, resp_way_41, resp_evict_dirty_41
  );

  modport slave (
    input  req_valid_41, req_addr_41, req_write_41,
    output req_ready_41, resp_valid_41, resp_hit_41, resp_way_41, resp_evict_dirty_41
  );
endinterface

// File: rtl/sector_lru_cache_sim.sv
// Set-associative cache hit/miss model with true-LRU, dirty/writeback tracking
// and saturating statistics. Define SECTOR_VALID_EN for per-sector valid bits.
module sector_lru_cache_sim #(
  parameter int ADDR_W       = 31,
  parameter int CACHE_BYTES  = 131072,
  parameter int LINE_BYTES   = 16,
  parameter int WAYS         = 32,
  parameter int SECTOR_BYTES = 4,
  parameter int CNT_W        = 31
) (
  input  logic             clk_41,
  input  logic             rst_41,
  sector_lru_cache_sim_if.slave bus,
  output logic [CNT_W-1:0] hits_41,
  output logic [CNT_W-1:0] misses_41,
  output logic [CNT_W-1:0] writebacks_41,
  output logic [CNT_W-1:0] sector_misses_41
);

  localparam int WAYS_E  = (WAYS == 0) ? CACHE_BYTES / LINE_BYTES : WAYS;
  localparam int SETS    = CACHE_BYTES / (LINE_BYTES * WAYS_E);
  localparam int OFF_W   = $clog2(LINE_BYTES);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - OFF_W - IDX_W;
  localparam int SECTORS = LINE_BYTES / SECTOR_BYTES;
  localparam int SEC_W   = $clog2(SECTORS);
  localparam int SOFF_W  = $clog2(SECTOR_BYTES);
  localparam int WAY_W   = (WAYS_E > 1) ? $clog2(WAYS_E) : 1;
  localparam int IDX_WS  = (IDX_W > 0) ? IDX_W : 1;
  localparam int SEC_WS  = (SEC_W > 0) ? SEC_W : 1;

  if (((LINE_BYTES & (LINE_BYTES - 1)) != 0) ||
      ((SECTOR_BYTES & (SECTOR_BYTES - 1)) != 0) ||
      (SECTOR_BYTES > LINE_BYTES) ||
      ((CACHE_BYTES % (LINE_BYTES * WAYS_E)) != 0) ||
      ((SETS & (SETS - 1)) != 0)) begin : g_bad_params
    $error("sector_lru_cache_sim: illegal cache geometry");
  end

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_t;
  state_t state, state_n;

  logic ready, do_lookup, do_update;

  logic [TAG_W-1:0]  tag_q;
  logic [IDX_WS-1:0] set_q, req_set;
  logic              write_q;

  logic [TAG_W-1:0] tag_mem   [SETS][WAYS_E];
  logic             valid_mem [SETS][WAYS_E];
  logic             dirty_mem [SETS][WAYS_E];
  logic [WAY_W-1:0] age_mem   [SETS][WAYS_E];

  logic             hit_found, inv_found;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way, chosen;

  logic             lk_match, lk_evict, full_hit;
  logic [WAY_W-1:0] lk_way, lk_age;

  logic             resp_valid_q, resp_hit_q, resp_evict_q;
  logic [WAY_W-1:0] resp_way_q;
  logic [CNT_W-1:0] hits_q, misses_q, wbs_q;

  if (IDX_W > 0) begin : g_idx
    assign req_set = bus.req_addr_41[OFF_W +: IDX_WS];
  end else begin : g_noidx
    assign req_set = '0;
  end

`ifdef SECTOR_VALID_EN
  logic [SECTORS-1:0] sec_mem [SETS][WAYS_E];
  logic [SEC_WS-1:0]  sec_q, req_sec;
  logic               lk_sec_ok;
  logic [CNT_W-1:0]   sms_q;

  if (SEC_W > 0) begin : g_sec
    assign req_sec = bus.req_addr_41[SOFF_W +: SEC_WS];
  end else begin : g_nosec
    assign req_sec = '0;
  end

  assign full_hit         = lk_match & lk_sec_ok;
  assign sector_misses_41 = sms_q;
`else
  assign full_hit         = lk_match;
  assign sector_misses_41 = '0;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_41 or posedge rst_41) begin
    if (rst_41) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.req_valid_41) state_n = LOOKUP;
      LOOKUP:  state_n = UPDATE;
      UPDATE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    do_lookup = 1'b0;
    do_update = 1'b0;
    case (state)
      IDLE:    ready     = 1'b1;
      LOOKUP:  do_lookup = 1'b1;
      UPDATE:  do_update = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_41 or posedge rst_41) begin
    if (rst_41) begin
      tag_q   <= '0;
      set_q   <= '0;
      write_q <= 1'b0;
`ifdef SECTOR_VALID_EN
      sec_q   <= '0;
`endif
    end else if (ready && bus.req_valid_41) begin
      tag_q   <= bus.req_addr_41[ADDR_W-1 -: TAG_W];
      set_q   <= req_set;
      write_q <= bus.req_write_41;
`ifdef SECTOR_VALID_EN
      sec_q   <= req_sec;
`endif
    end
  end

  // Scan from the top way down so the lowest matching index wins.
  always_comb begin
    hit_found = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = WAYS_E - 1; w >= 0; w--) begin
      if (valid_mem[set_q][w] && (tag_mem[set_q][w] == tag_q)) begin
        hit_found = 1'b1;
        hit_way   = WAY_W'(w);
      end
      if (!valid_mem[set_q][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_mem[set_q][w] == '0) lru_way = WAY_W'(w);
    end
    chosen = hit_found ? hit_way : (inv_found ? inv_way : lru_way);
  end

  always_ff @(posedge clk_41 or posedge rst_41) begin
    if (rst_41) begin
      lk_match  <= 1'b0;
      lk_way    <= '0;
      lk_age    <= '0;
      lk_evict  <= 1'b0;
`ifdef SECTOR_VALID_EN
      lk_sec_ok <= 1'b0;
`endif
    end else if (do_lookup) begin
      lk_match  <= hit_found;
      lk_way    <= chosen;
      lk_age    <= age_mem[set_q][chosen];
      lk_evict  <= !hit_found && valid_mem[set_q][chosen] && dirty_mem[set_q][chosen];
`ifdef SECTOR_VALID_EN
      lk_sec_ok <= sec_mem[set_q][chosen][sec_q];
`endif
    end
  end

  // Line state; the later age write to the accessed way overrides its decrement.
  always_ff @(posedge clk_41 or posedge rst_41) begin
    if (rst_41) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS_E; w++) begin
          valid_mem[s][w] <= 1'b0;
          dirty_mem[s][w] <= 1'b0;
          age_mem[s][w]   <= WAY_W'(w);
`ifdef SECTOR_VALID_EN
          sec_mem[s][w]   <= '0;
`endif
        end
      end
    end else if (do_update) begin
      for (int w = 0; w < WAYS_E; w++) begin
        if (age_mem[set_q][w] > lk_age) age_mem[set_q][w] <= age_mem[set_q][w] - 1'b1;
      end
      age_mem[set_q][lk_way] <= WAY_W'(WAYS_E - 1);
      if (lk_match) begin
        dirty_mem[set_q][lk_way] <= dirty_mem[set_q][lk_way] | write_q;
`ifdef SECTOR_VALID_EN
        sec_mem[set_q][lk_way][sec_q] <= 1'b1;
`endif
      end else begin
        valid_mem[set_q][lk_way] <= 1'b1;
        dirty_mem[set_q][lk_way] <= write_q;
`ifdef SECTOR_VALID_EN
        sec_mem[set_q][lk_way] <= SECTORS'(1) << sec_q;
`endif
      end
    end
  end

  always_ff @(posedge clk_41) begin
    if (do_update && !lk_match) tag_mem[set_q][lk_way] <= tag_q;
  end

  always_ff @(posedge clk_41 or posedge rst_41) begin
    if (rst_41) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      resp_evict_q <= 1'b0;
      hits_q       <= '0;
      misses_q     <= '0;
      wbs_q        <= '0;
`ifdef SECTOR_VALID_EN
      sms_q        <= '0;
`endif
    end else begin
      resp_valid_q <= do_update;
      if (do_update) begin
        resp_hit_q   <= full_hit;
        resp_way_q   <= lk_way;
        resp_evict_q <= lk_evict;
        if (full_hit) hits_q   <= sat_inc(hits_q);
        else          misses_q <= sat_inc(misses_q);
        if (lk_evict) wbs_q    <= sat_inc(wbs_q);
`ifdef SECTOR_VALID_EN
        if (lk_match && !lk_sec_ok) sms_q <= sat_inc(sms_q);
`endif
      end
    end
  end

  assign bus.req_ready_41        = ready;
  assign bus.resp_valid_41       = resp_valid_q;
  assign bus.resp_hit_41         = resp_hit_q;
  assign bus.resp_way_41         = resp_way_q;
  assign bus.resp_evict_dirty_41 = resp_evict_q;
  assign hits_41                 = hits_q;
  assign misses_41               = misses_q;
  assign writebacks_41           = wbs_q;

endmodule

// File: tb/tb_sector_lru_cache_sim.sv
// Directed, table-driven bench for sector_lru_cache_sim (default geometry) plus
// a CNT_W=4 instance fed the same requests for counter saturation.
module tb_sector_lru_cache_sim;

`ifdef SECTOR_VALID_EN
  localparam bit SEC_EN = 1'b1;
`else
  localparam bit SEC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sector_lru_cache_sim_if #(.ADDR_W(31), .WAY_W(5)) bus ();
  sector_lru_cache_sim_if #(.ADDR_W(31), .WAY_W(5)) bus_sat ();

  assign bus_sat.req_valid_41 = bus.req_valid_41;
  assign bus_sat.req_addr_41  = bus.req_addr_41;
  assign bus_sat.req_write_41 = bus.req_write_41;

  logic [30:0] hits, misses, wbs, sms;
  logic [3:0]  hits_s, misses_s, wbs_s, sms_s;

  sector_lru_cache_sim dut (
    .clk_41(clk), .rst_41(rst), .bus(bus),
    .hits_41(hits), .misses_41(misses), .writebacks_41(wbs), .sector_misses_41(sms)
  );

  sector_lru_cache_sim #(.CNT_W(4)) dut_sat (
    .clk_41(clk), .rst_41(rst), .bus(bus_sat),
    .hits_41(hits_s), .misses_41(misses_s), .writebacks_41(wbs_s), .sector_misses_41(sms_s)
  );

  typedef struct {
    bit          do_reset;
    logic [30:0] addr;
    bit          write;
    bit          hit;
    int          way;
    bit          evict;
    int          hits;
    int          misses;
    int          wbs;
    int          sms;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(bit r, logic [30:0] a, bit w, bit h, int way, bit ev,
                              int nh, int nm, int nw, int ns);
    vec_t v;
    v = '{r, a, w, h, way, ev, nh, nm, nw, ns};
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid_41 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // lat = clock edges after the accepting edge until resp_valid is seen (-1 on timeout).
  task automatic applyStimulus(input logic [30:0] addr, input bit wr, output bit hit,
                               output int way, output bit ev, output int lat);
    int  guard;
    bit  seen;
    guard = 0;
    seen  = 1'b0;
    lat   = -1;
    @(negedge clk);
    while (!bus.req_ready_41 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid_41 = 1'b1;
    bus.req_addr_41  = addr;
    bus.req_write_41 = wr;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_41 = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      if (!seen) begin
        @(posedge clk);
        #1;
        if (bus.resp_valid_41) begin
          seen = 1'b1;
          lat  = e;
        end
      end
    end
    hit = bus.resp_hit_41;
    way = int'(bus.resp_way_41);
    ev  = bus.resp_evict_dirty_41;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit hit, ev, saw;
    int way, lat, n_acc, guard;
    int acc_cyc[8];

    // Geometry: 256 sets, 32 ways; k*4096 all land in set 0 with tag k.
    add(1, 31'h100, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 31'h100, 0, 1, 0, 0, 1, 1, 0, 0);

    for (int k = 0; k < 32; k++) add(k == 0, 31'(k * 4096), 0, 0, k, 0, 0, k + 1, 0, 0);
    add(0, 31'(32 * 4096), 0, 0, 0, 0, 0, 33, 0, 0);
    add(0, 31'h0,          0, 0, 1, 0, 0, 34, 0, 0);
    add(0, 31'(8192),      0, 1, 2, 0, 1, 34, 0, 0);

    add(1, 31'h0, 1, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k < 32; k++) add(0, 31'(k * 4096), 0, 0, k, 0, 0, k + 1, 0, 0);
    add(0, 31'(32 * 4096), 0, 0, 0, 1, 0, 33, 1, 0);
    add(0, 31'(33 * 4096), 0, 0, 1, 0, 0, 34, 1, 0);

    add(1, 31'h0, 0, 0, 0, 0, 0, 1, 0, 0);
    if (SEC_EN) begin
      add(0, 31'h4, 0, 0, 0, 0, 0, 2, 0, 1);
      add(0, 31'h4, 0, 1, 0, 0, 1, 2, 0, 1);
    end else begin
      add(0, 31'h4, 0, 1, 0, 0, 1, 1, 0, 0);
      add(0, 31'h4, 0, 1, 0, 0, 2, 1, 0, 0);
    end

    add(1, 31'h0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 31'h0, 1, 1, 0, 0, 1, 1, 0, 0);
    for (int k = 1; k < 32; k++) add(0, 31'(k * 4096), 0, 0, k, 0, 1, k + 1, 0, 0);
    add(0, 31'(32 * 4096), 0, 0, 0, 1, 1, 33, 1, 0);

    add(1, 31'h200, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i < 20; i++) add(0, 31'h200, 0, 1, 0, 0, i, 1, 0, 0);

    bus.req_valid_41 = 1'b0;
    bus.req_addr_41  = '0;
    bus.req_write_41 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset req_ready", int'(bus.req_ready_41), 1);
    checkOutput("reset resp_valid", int'(bus.resp_valid_41), 0);
    checkOutput("reset resp_hit", int'(bus.resp_hit_41), 0);
    checkOutput("reset resp_way", int'(bus.resp_way_41), 0);
    checkOutput("reset resp_evict", int'(bus.resp_evict_dirty_41), 0);
    checkOutput("reset hits", int'(hits), 0);
    checkOutput("reset misses", int'(misses), 0);
    checkOutput("reset writebacks", int'(wbs), 0);
    checkOutput("reset sector_misses", int'(sms), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_reset) doReset();
      applyStimulus(vecs[i].addr, vecs[i].write, hit, way, ev, lat);
      checkOutput($sformatf("v%0d latency", i), lat, 2);
      checkOutput($sformatf("v%0d hit", i), int'(hit), int'(vecs[i].hit));
      checkOutput($sformatf("v%0d way", i), way, vecs[i].way);
      checkOutput($sformatf("v%0d evict_dirty", i), int'(ev), int'(vecs[i].evict));
      checkOutput($sformatf("v%0d hits", i), int'(hits), vecs[i].hits);
      checkOutput($sformatf("v%0d misses", i), int'(misses), vecs[i].misses);
      checkOutput($sformatf("v%0d writebacks", i), int'(wbs), vecs[i].wbs);
      checkOutput($sformatf("v%0d sector_misses", i), int'(sms), vecs[i].sms);
    end

    checkOutput("sat hits", int'(hits_s), 15);
    checkOutput("sat misses", int'(misses_s), 1);
    checkOutput("sat writebacks", int'(wbs_s), 0);
    checkOutput("sat sector_misses", int'(sms_s), 0);

    // Response strobe lasts one cycle and fields hold afterwards.
    doReset();
    applyStimulus(31'h300, 1'b0, hit, way, ev, lat);
    applyStimulus(31'h300, 1'b0, hit, way, ev, lat);
    @(posedge clk);
    #1;
    checkOutput("pulse resp_valid low", int'(bus.resp_valid_41), 0);
    checkOutput("pulse resp_hit held", int'(bus.resp_hit_41), 1);
    checkOutput("pulse resp_way held", int'(bus.resp_way_41), 0);

    // Continuous valid: acceptance every third cycle.
    doReset();
    @(negedge clk);
    bus.req_valid_41 = 1'b1;
    bus.req_addr_41  = 31'h400;
    bus.req_write_41 = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 13; c++) begin
      if (bus.req_ready_41 && n_acc < 8) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      @(negedge clk);
    end
    bus.req_valid_41 = 1'b0;
    guard = 0;
    while (!bus.req_ready_41 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("stream acceptances", n_acc, 5);
    for (int i = 1; i < 5; i++)
      checkOutput($sformatf("stream gap %0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
    checkOutput("stream hits", int'(hits), 4);
    checkOutput("stream misses", int'(misses), 1);

    // Reset during LOOKUP discards the request and flushes the cache.
    doReset();
    applyStimulus(31'h500, 1'b0, hit, way, ev, lat);
    checkOutput("prefill hit", int'(hit), 0);
    @(negedge clk);
    bus.req_valid_41 = 1'b1;
    bus.req_addr_41  = 31'h500;
    bus.req_write_41 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_41 = 1'b0;
    rst = 1'b1;
    saw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid_41) saw = 1'b1;
    end
    checkOutput("midrst no resp", int'(saw), 0);
    checkOutput("midrst hits", int'(hits), 0);
    checkOutput("midrst misses", int'(misses), 0);
    checkOutput("midrst req_ready", int'(bus.req_ready_41), 1);
    applyStimulus(31'h500, 1'b0, hit, way, ev, lat);
    checkOutput("midrst refetch hit", int'(hit), 0);
    checkOutput("midrst refetch misses", int'(misses), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
